// File: rtl/fir_decimator.sv
// Accumulate-and-dump decimator behind the 16-tap FIR stage.
// The frame FSM sums R accepted samples and dumps the sum into a
// registered pipeline. The pipeline applies a rounding right-shift,
// saturates to OUT_WIDTH and places the result in a one-deep
// valid/ready output register. The sticky flag sat records clipped
// results, and the sticky flag overrun records results that were lost.
//
// Frame FSM states
//   state    | meaning
//   ST_IDLE  | no frame open; the next accepted sample starts a frame
//   ST_ACC   | frame open; acc holds the partial sum of cnt samples
//
// Pipeline: the dump edge writes the sum into sum_*. The next edge writes
// the rounded/saturated value into res_*. The edge after that loads dout.
// The last sample of a frame is accepted at edge t, and dout_valid
// therefore rises after edge t+2.
module fir_decimator #(
    parameter int IN_WIDTH  = 30,
    parameter int OUT_WIDTH = 16,
    parameter int DEC_LOG2  = 10,
    parameter int ACC_WIDTH = IN_WIDTH + DEC_LOG2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clear,
    input  logic signed [IN_WIDTH-1:0]  din,
    input  logic                        din_valid,
    input  logic [DEC_LOG2:0]           dec_ratio,
    input  logic [5:0]                  shift,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        sat,
    output logic                        overrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    // The extra bit absorbs the rounding carry.
    localparam int EW = ACC_WIDTH + 1;

    localparam logic [DEC_LOG2:0]    CNT_ONE = {{DEC_LOG2{1'b0}}, 1'b1};
    localparam logic [DEC_LOG2:0]    R_MAX   = {1'b1, {DEC_LOG2{1'b0}}};
    localparam logic [5:0]           SH_MAX  = 6'(ACC_WIDTH - 1);
    localparam logic signed [EW-1:0] EXT_ONE = {{(EW-1){1'b0}}, 1'b1};

    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                        flush;
    logic                        accept;
    logic [0:0]                  state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [DEC_LOG2:0]           cnt;
    logic [DEC_LOG2:0]           r_lat;
    logic [5:0]                  sh_lat;

    logic [DEC_LOG2:0]           ratio_clamped;
    logic [5:0]                  shift_clamped;
    logic signed [ACC_WIDTH-1:0] din_ext;
    logic signed [ACC_WIDTH-1:0] frame_sum;
    logic [DEC_LOG2:0]           cnt_next;
    logic [DEC_LOG2:0]           ratio_eff;
    logic [5:0]                  shift_eff;
    logic                        dump;

    logic                        sum_valid;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic [5:0]                  sum_sh;

    logic signed [EW-1:0]        sum_ext;
    logic signed [EW-1:0]        round_bias;
    logic signed [EW-1:0]        rounded;
    logic signed [EW-1:0]        shifted;
    logic [EW-OUT_WIDTH:0]       shifted_hi;
    logic                        clip_hi;
    logic                        clip_lo;
    logic signed [OUT_WIDTH-1:0] sat_val;

    logic                        res_valid;
    logic                        res_clip;
    logic signed [OUT_WIDTH-1:0] res_val;

    // rst and clear act identically. rst wins only in the sense that either flushes.
    assign flush  = rst | clear;
    assign accept = en & din_valid;

    // A ratio of 0 means 1. Ratios above 2^DEC_LOG2 clamp. Shifts stay below ACC_WIDTH.
    always_comb begin
        ratio_clamped = dec_ratio;
        if (dec_ratio == '0) begin
            ratio_clamped = CNT_ONE;
        end else if (dec_ratio > R_MAX) begin
            ratio_clamped = R_MAX;
        end
        shift_clamped = (shift > SH_MAX) ? SH_MAX : shift;
    end

    assign din_ext = {{DEC_LOG2{din[IN_WIDTH-1]}}, din};

    // Candidate next frame state. A sample arriving in IDLE opens a frame with the live controls.
    always_comb begin
        if (state == ST_IDLE) begin
            frame_sum = din_ext;
            cnt_next  = CNT_ONE;
            ratio_eff = ratio_clamped;
            shift_eff = shift_clamped;
        end else begin
            frame_sum = acc + din_ext;
            cnt_next  = cnt + CNT_ONE;
            ratio_eff = r_lat;
            shift_eff = sh_lat;
        end
    end

    assign dump = accept && (cnt_next == ratio_eff);

    // Frame FSM. The FSM holds when no sample is accepted, and it returns to IDLE on every dump, so frames are gapless.
    always_ff @(posedge clk) begin
        if (flush) begin
            state  <= ST_IDLE;
            acc    <= '0;
            cnt    <= '0;
            r_lat  <= '0;
            sh_lat <= '0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                r_lat  <= ratio_clamped;
                sh_lat <= shift_clamped;
            end
            if (dump) begin
                state <= ST_IDLE;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                state <= ST_ACC;
                acc   <= frame_sum;
                cnt   <= cnt_next;
            end
        end
    end

    // Stage 1: capture the completed frame sum together with its shift.
    always_ff @(posedge clk) begin
        if (flush) begin
            sum_valid <= 1'b0;
            sum_q     <= '0;
            sum_sh    <= '0;
        end else begin
            sum_valid <= dump;
            if (dump) begin
                sum_q  <= frame_sum;
                sum_sh <= shift_eff;
            end
        end
    end

    // Round half up (toward +inf on ties), shift arithmetically, then saturate.
    always_comb begin
        sum_ext    = {sum_q[ACC_WIDTH-1], sum_q};
        round_bias = (sum_sh == 6'd0) ? '0 : (EXT_ONE <<< (sum_sh - 6'd1));
        rounded    = sum_ext + round_bias;
        shifted    = rounded >>> sum_sh;
        shifted_hi = shifted[EW-1:OUT_WIDTH-1];
        clip_hi    = !shifted[EW-1] && (|shifted_hi);
        clip_lo    = shifted[EW-1] && !(&shifted_hi);
        if (clip_hi) begin
            sat_val = OUT_MAX;
        end else if (clip_lo) begin
            sat_val = OUT_MIN;
        end else begin
            sat_val = shifted[OUT_WIDTH-1:0];
        end
    end

    // Rescaled result register. It advances regardless of en so that in-flight results complete.
    always_ff @(posedge clk) begin
        if (flush) begin
            res_valid <= 1'b0;
            res_clip  <= 1'b0;
            res_val   <= '0;
        end else begin
            res_valid <= sum_valid;
            res_clip  <= sum_valid & (clip_hi | clip_lo);
            if (sum_valid) begin
                res_val <= sat_val;
            end
        end
    end

    // Output register with handshake. A consume and a load in the same cycle lose nothing. A result that arrives while the register is full is dropped.
    always_ff @(posedge clk) begin
        if (flush) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sat        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (res_valid) begin
                if (res_clip) begin
                    sat <= 1'b1;
                end
                if (!dout_valid || dout_ready) begin
                    dout       <= res_val;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator: directed scenarios with literal
// expectations plus a randomized run against a frame-level reference model.
module tb_fir_decimator;

    localparam int IN_WIDTH  = 30;
    localparam int OUT_WIDTH = 16;
    localparam int DEC_LOG2  = 10;

    logic                        clk;
    logic                        rst;
    logic                        en;
    logic                        clear;
    logic signed [IN_WIDTH-1:0]  din;
    logic                        din_valid;
    logic [DEC_LOG2:0]           dec_ratio;
    logic [5:0]                  shift;
    logic signed [OUT_WIDTH-1:0] dout;
    logic                        dout_valid;
    logic                        dout_ready;
    logic                        sat;
    logic                        overrun;

    int n_chk  = 0;
    int n_fail = 0;

    fir_decimator #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .DEC_LOG2 (DEC_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clear     (clear),
        .din       (din),
        .din_valid (din_valid),
        .dec_ratio (dec_ratio),
        .shift     (shift),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .sat       (sat),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    typedef struct {
        int     due;
        longint val;
        bit     clip;
    } res_t;

    res_t   pq[$];
    int     m_cyc = 0;
    int     m_cnt = 0;
    int     m_r   = 1;
    int     m_sh  = 0;
    longint m_sum = 0;
    longint m_dout = 0;
    bit     m_dv  = 0;
    bit     m_sat = 0;
    bit     m_ovr = 0;

    function automatic longint rescale(input longint s, input int sh, output bit clip);
        longint q;
        q = (s + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0)) >>> sh;
        clip = 1'b0;
        if (q > 32767) begin
            q = 32767;
            clip = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            clip = 1'b1;
        end
        return q;
    endfunction

    function automatic int clamp_ratio(input int r);
        if (r == 0) return 1;
        if (r > 1024) return 1024;
        return r;
    endfunction

    function automatic void model_edge();
        res_t r;
        bit   c;
        m_cyc++;
        if (rst || clear) begin
            m_cnt = 0;
            m_sum = 0;
            pq.delete();
            m_dv   = 0;
            m_dout = 0;
            m_sat  = 0;
            m_ovr  = 0;
            return;
        end
        if (pq.size() > 0 && pq[0].due == m_cyc) begin
            r = pq.pop_front();
            if (r.clip) m_sat = 1;
            if (!m_dv || dout_ready) begin
                m_dout = r.val;
                m_dv   = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_dv && dout_ready) begin
            m_dv = 0;
        end
        if (en && din_valid) begin
            if (m_cnt == 0) begin
                m_r   = clamp_ratio(int'(dec_ratio));
                m_sh  = int'(shift);
                m_sum = 0;
            end
            m_sum += longint'(din);
            m_cnt++;
            if (m_cnt == m_r) begin
                r.val  = rescale(m_sum, m_sh, c);
                r.clip = c;
                r.due  = m_cyc + 2;
                pq.push_back(r);
                m_cnt = 0;
            end
        end
    endfunction

    // Advance the model at every edge and compare the DUT just after it.
    always @(posedge clk) begin
        model_edge();
        #1;
        chk("dout_valid", longint'(dout_valid), longint'(m_dv));
        if (m_dv) chk("dout", longint'(dout), m_dout);
        chk("sat", longint'(sat), longint'(m_sat));
        chk("overrun", longint'(overrun), longint'(m_ovr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!dout_valid && n < max_cycles) begin
            step();
            n++;
        end
        chk("wait_valid", longint'(dout_valid), 1);
    endtask

    task automatic feed(input longint v);
        din = IN_WIDTH'(v);
        din_valid = 1'b1;
        step();
    endtask

    // ---------------- scenarios ----------------
    initial begin
        bit c;
        int sel;
        rst = 1'b1;
        en = 1'b1;
        clear = 1'b0;
        din = '0;
        din_valid = 1'b0;
        dec_ratio = 11'd4;
        shift = 6'd2;
        dout_ready = 1'b1;

        // Pin the model's rounding/saturation with hand-computed values.
        chk("model_round_neg", rescale(-5, 1, c), -2);
        chk("model_round_pos", rescale(5, 1, c), 3);
        chk("model_tie_neg", rescale(-6, 2, c), -1);
        chk("model_sat_hi", rescale(40000, 0, c), 32767);
        chk("model_sat_hi_flag", longint'(c), 1);
        chk("model_sat_lo", rescale(-40000, 0, c), -32768);

        step();
        step();
        chk("reset_dout", longint'(dout), 0);
        chk("reset_dout_valid", longint'(dout_valid), 0);
        chk("reset_sat", longint'(sat), 0);
        chk("reset_overrun", longint'(overrun), 0);

        // 1: R=4, shift=2, constant 1000.
        rst = 1'b0;
        dec_ratio = 11'd4;
        shift = 6'd2;
        din = 30'sd1000;
        din_valid = 1'b1;
        repeat (5) step();
        chk("t1_latency_early", longint'(dout_valid), 0);
        step();
        chk("t1_first_valid", longint'(dout_valid), 1);
        chk("t1_first_dout", longint'(dout), 1000);
        repeat (3) step();
        chk("t1_gap", longint'(dout_valid), 0);
        step();
        chk("t1_second_valid", longint'(dout_valid), 1);
        chk("t1_second_dout", longint'(dout), 1000);
        chk("t1_sat", longint'(sat), 0);

        // 2: R=2, shift=1, rounding.
        do_reset();
        dec_ratio = 11'd2;
        shift = 6'd1;
        feed(-3);
        feed(-2);
        din_valid = 1'b0;
        wait_valid(10);
        chk("t2_neg_round", longint'(dout), -2);
        feed(3);
        feed(2);
        din_valid = 1'b0;
        wait_valid(10);
        chk("t2_pos_round", longint'(dout), 3);

        // 3: R=0 acts as 1, saturation both ways, sticky sat.
        do_reset();
        dec_ratio = 11'd0;
        shift = 6'd0;
        feed(40000);
        din_valid = 1'b0;
        wait_valid(10);
        chk("t3_sat_hi", longint'(dout), 32767);
        chk("t3_sat_flag", longint'(sat), 1);
        feed(-40000);
        din_valid = 1'b0;
        wait_valid(10);
        chk("t3_sat_lo", longint'(dout), -32768);
        repeat (4) step();
        chk("t3_sat_sticky", longint'(sat), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t3_sat_cleared", longint'(sat), 0);

        // 4: backpressure and overrun.
        do_reset();
        dec_ratio = 11'd1;
        shift = 6'd0;
        dout_ready = 1'b0;
        feed(5);
        feed(6);
        feed(7);
        din_valid = 1'b0;
        step();
        step();
        chk("t4_held_valid", longint'(dout_valid), 1);
        chk("t4_held_dout", longint'(dout), 5);
        chk("t4_overrun", longint'(overrun), 1);
        dout_ready = 1'b1;
        step();
        chk("t4_consumed", longint'(dout_valid), 0);
        feed(9);
        din_valid = 1'b0;
        wait_valid(10);
        chk("t4_flow", longint'(dout), 9);
        chk("t4_overrun_sticky", longint'(overrun), 1);

        // 5: ratio change mid-frame, then reset mid-frame.
        do_reset();
        dec_ratio = 11'd4;
        shift = 6'd0;
        feed(1);
        feed(1);
        dec_ratio = 11'd8;
        feed(1);
        feed(1);
        din_valid = 1'b0;
        wait_valid(10);
        chk("t5_old_ratio", longint'(dout), 4);
        repeat (8) feed(1);
        din_valid = 1'b0;
        wait_valid(10);
        chk("t5_new_ratio", longint'(dout), 8);
        repeat (3) feed(1);
        rst = 1'b1;
        din_valid = 1'b0;
        step();
        chk("t5_rst_valid", longint'(dout_valid), 0);
        chk("t5_rst_dout", longint'(dout), 0);
        rst = 1'b0;
        dec_ratio = 11'd2;
        feed(7);
        feed(7);
        din_valid = 1'b0;
        wait_valid(10);
        chk("t5_clean_frame", longint'(dout), 14);

        // 6: en pause mid-frame with garbage on din.
        do_reset();
        dec_ratio = 11'd4;
        shift = 6'd0;
        feed(10);
        feed(20);
        en = 1'b0;
        for (int i = 0; i < 5; i++) feed(longint'($urandom_range(0, 100000)));
        en = 1'b1;
        feed(30);
        feed(40);
        din_valid = 1'b0;
        step();
        chk("t6_not_yet", longint'(dout_valid), 0);
        step();
        chk("t6_valid", longint'(dout_valid), 1);
        chk("t6_sum", longint'(dout), 100);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            din_valid  = ($urandom_range(0, 4) != 0);
            dout_ready = ($urandom_range(0, 9) < 7);
            clear      = ($urandom_range(0, 499) == 0);
            sel = int'($urandom_range(0, 3));
            if (sel == 0) din = IN_WIDTH'($urandom);
            else din = IN_WIDTH'(int'($urandom_range(0, 2000)) - 1000);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 29) == 0) dec_ratio = 11'($urandom_range(1000, 2047));
                else dec_ratio = 11'($urandom_range(0, 9));
                shift = 6'($urandom_range(0, 39));
            end
            step();
        end
        din_valid = 1'b0;
        clear = 1'b0;
        dout_ready = 1'b1;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream consumer of the 16-tap low-pass FIR stage.
- Takes the FIR's full-precision signed output at the ADC sample rate and performs accumulate-and-dump decimation by a runtime ratio R.
- Rescales the sum with a runtime rounding right-shift, saturates it to a narrow word, and hands each result to the next stage (loop filter / readout) over a valid/ready handshake.
- Holds one result and flags overruns.

Parameters:
- IN_WIDTH, 30, width of signed FIR output sample (ADC width 14 + 16).
- OUT_WIDTH, 16, width of signed decimated output.
- DEC_LOG2, 10, log2 of maximum decimation ratio (R max = 1024).
- ACC_WIDTH, IN_WIDTH+DEC_LOG2, accumulator width; guarantees no accumulator overflow.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  1 = accept input samples; 0 = pause, all state held.
- clear  in  1  synchronous flush of frame, pipeline, output and sticky flags.
- din  in  IN_WIDTH  signed FIR output sample.
- din_valid  in  1  din qualifier; sample accepted when din_valid & en.
- dec_ratio  in  DEC_LOG2+1  decimation ratio R, unsigned; 0 treated as 1; values >2^DEC_LOG2 clamp to 2^DEC_LOG2.
- shift  in  6  right-shift applied to frame sum, 0..ACC_WIDTH-1.
- dout  out  OUT_WIDTH  signed decimated result.
- dout_valid  out  1  dout holds an unconsumed result.
- dout_ready  in  1  consumer accepts dout when dout_valid & dout_ready.
- sat  out  1  sticky: some result was clipped.
- overrun  out  1  sticky: some result was dropped because the output register was still full.

Behaviour:
- Reset (rst=1 at clk edge):
  - acc=0, cnt=0, frame FSM=IDLE, stage-1 valid=0.
  - dout=0, dout_valid=0, sat=0, overrun=0.
  - rst has priority over clear; clear has the same effect as rst.
- Frame FSM, states IDLE and ACC:
  - IDLE: on an accepted sample, latch R_lat (clamped dec_ratio) and sh_lat (shift); acc=din sign-extended; cnt=1.
    - If R_lat==1, dump immediately and stay IDLE.
    - Otherwise go to ACC.
  - ACC: on an accepted sample, acc+=din, cnt+=1.
    - When the accepted sample makes cnt==R_lat, dump: sum=acc+din goes to stage 1, acc/cnt are zeroed, FSM returns to IDLE.
  - A sample arriving in the cycle after a dump is accepted as the first of a new frame; there are no dead cycles, so back-to-back frames are gapless.
  - dec_ratio and shift changes mid-frame take effect at the next frame start only.
  - en=0 or din_valid=0: the frame FSM, acc and cnt hold.
- Stage 1 (registered sum):
  - rounded = sum + (sh_lat>0 ? 2^(sh_lat-1) : 0).
  - Arithmetic right-shift by sh_lat; round-half-up, toward +inf on ties.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; set sat if clipped.
- Stage 2 (output register):
  - The result loads into dout with dout_valid=1 if dout_valid==0, or if dout_valid & dout_ready in that cycle (simultaneous consume and load is lossless).
  - Otherwise the result is dropped, dout is unchanged, and overrun is set.
  - dout_valid clears on handshake when no new result is loading.
  - Stage 1 and stage 2 advance regardless of en, so in-flight results still complete.
- Latency: final sample of a frame accepted at edge t -> dout_valid=1 after edge t+2.
- dout is stable while dout_valid=1 and dout_ready=0.
- sat and overrun clear only on rst or clear.
- Width rule: all arithmetic is signed ACC_WIDTH+1 (the extra bit covers rounding carry); no intermediate wrap-around is permitted.

Test Plan:
1. rst, dec_ratio=4, shift=2, din=1000 constant, din_valid=1, dout_ready=1 -> dout=1000 pulses every 4 cycles; first dout_valid 2 cycles after the 4th sample; sat=0.
2. dec_ratio=2, shift=1, din sequence -3,-2 -> sum -5, (-5+1)>>>1 = -2; sequence 3,2 -> 3.
3. dec_ratio=0 (acts as 1), shift=0, din=40000 then -40000 -> dout=32767 then -32768; sat=1 sticky until clear.
4. dec_ratio=1, dout_ready=0 for 3 results -> first result held stable, next two dropped, overrun=1; raise dout_ready -> first result consumed, then new results flow.
5. Mid-frame: after 2 of 4 samples, change dec_ratio to 8 -> current frame dumps at 4; next frame at 8. Assert rst mid-frame -> all outputs 0 next cycle, next frame starts clean.
6. en toggled low for 5 cycles mid-frame with din garbage -> output equals the sum of enabled samples only; dout_valid timing is shifted by the 5 paused cycles.
